// File: rtl/dlk_bound_table.sv
// Per-buffer fill-bound table: records how far byte-store runs have filled each
// buffer and flags loads that read past the filled end of the same buffer.
module dlk_bound_table #(
  parameter int unsigned N      = 8,
  parameter int unsigned AW     = 32,
  parameter int unsigned WINDOW = 64,
  localparam int unsigned CW    = $clog2(N + 1),
  localparam int unsigned IW    = $clog2(N)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clear_i,
  input  logic          st_valid_i,
  input  logic [AW-1:0] st_base_i,
  input  logic [AW-1:0] st_addr_i,
  input  logic          ld_valid_i,
  input  logic [AW-1:0] ld_base_i,
  input  logic [AW-1:0] ld_addr_i,
  output logic          overflow_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  input  logic [IW-1:0] dbg_idx_i,
  output logic [AW-1:0] dbg_base_o,
  output logic [AW-1:0] dbg_end_o
);

  logic [N-1:0]  valid_q;
  logic [AW-1:0] base_q [N];
  logic [AW:0]   end_q  [N];
  logic [IW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;

  logic          st_hit, ld_hit, st_ok;
  logic [IW-1:0] st_idx, ld_idx;
  logic [AW:0]   st_end;

  // Window limit is computed one bit wider so that bases near the top never wrap.
  function automatic logic [AW:0] lim_of(input logic [AW-1:0] b);
    return {1'b0, b} + (AW+1)'(WINDOW);
  endfunction

  function automatic logic in_win(input logic [AW-1:0] b, input logic [AW-1:0] a);
    return ({1'b0, a} >= {1'b0, b}) && ({1'b0, a} < lim_of(b));
  endfunction

  always_comb begin
    st_hit = 1'b0;
    st_idx = '0;
    ld_hit = 1'b0;
    ld_idx = '0;
    // Descending scan so the lowest matching index is the one left standing.
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (valid_q[i] && base_q[i] == st_base_i) begin
        st_hit = 1'b1;
        st_idx = IW'(i);
      end
      if (valid_q[i] && base_q[i] == ld_base_i) begin
        ld_hit = 1'b1;
        ld_idx = IW'(i);
      end
    end
    st_end = {1'b0, st_addr_i} + (AW+1)'(1);
    st_ok  = st_valid_i && in_win(st_base_i, st_addr_i);
    ovf_d  = ld_valid_i && ld_hit &&
             ({1'b0, ld_addr_i} >= end_q[ld_idx]) &&
             ({1'b0, ld_addr_i} < lim_of(base_q[ld_idx]));
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (st_ok && !st_hit) begin
      wr_ptr_d = wr_ptr_q + IW'(1);
      if (count_q != CW'(N)) count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(N); i++) begin
        base_q[i] <= '0;
        end_q[i]  <= '0;
      end
      valid_q  <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else if (clear_i) begin
      valid_q  <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      ovf_q    <= ovf_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      if (st_ok) begin
        if (st_hit) begin
          if (st_end > end_q[st_idx]) end_q[st_idx] <= st_end;
        end else begin
          valid_q[wr_ptr_q] <= 1'b1;
          base_q[wr_ptr_q]  <= st_base_i;
          end_q[wr_ptr_q]   <= st_end;
        end
      end
    end
  end

  assign overflow_o = ovf_q;
  assign count_o    = count_q;
  assign full_o     = (count_q == CW'(N));
  assign dbg_base_o = base_q[dbg_idx_i];
  assign dbg_end_o  = end_q[dbg_idx_i][AW-1:0];

endmodule

// File: tb/tb_dlk_bound_table.sv
// Randomized and directed bench for dlk_bound_table against an array-based
// reference model of the fill-bound rules.
module tb_dlk_bound_table;
  localparam int N = 8;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        clear_i = 1'b0;
  logic        st_valid_i = 1'b0;
  logic [31:0] st_base_i = '0, st_addr_i = '0;
  logic        ld_valid_i = 1'b0;
  logic [31:0] ld_base_i = '0, ld_addr_i = '0;
  logic        overflow_o, full_o;
  logic [3:0]  count_o;
  logic [2:0]  dbg_idx_i = '0;
  logic [31:0] dbg_base_o, dbg_end_o;

  dlk_bound_table #(.N(N), .AW(32), .WINDOW(64)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
    .st_valid_i(st_valid_i), .st_base_i(st_base_i), .st_addr_i(st_addr_i),
    .ld_valid_i(ld_valid_i), .ld_base_i(ld_base_i), .ld_addr_i(ld_addr_i),
    .overflow_o(overflow_o), .count_o(count_o), .full_o(full_o),
    .dbg_idx_i(dbg_idx_i), .dbg_base_o(dbg_base_o), .dbg_end_o(dbg_end_o)
  );

  always #10 clk_i = ~clk_i;

  int n_chk = 0, n_fail = 0;

  // Reference model: entries as plain arrays, addresses held in 64-bit arithmetic.
  bit          mv [N];
  logic [31:0] mb [N];
  logic [63:0] me [N];
  int          mptr, mcnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int find(input logic [31:0] b);
    for (int i = 0; i < N; i++) if (mv[i] && mb[i] == b) return i;
    return -1;
  endfunction

  task automatic model_reset(input bit full_rst);
    for (int i = 0; i < N; i++) begin
      mv[i] = 0;
      if (full_rst) begin mb[i] = '0; me[i] = '0; end
    end
    mptr = 0; mcnt = 0;
  endtask

  function automatic bit model_load(input logic [31:0] b, input logic [31:0] a);
    int h = find(b);
    logic [63:0] aa = {32'h0, a};
    if (h < 0) return 0;
    return (aa >= me[h]) && (aa < {32'h0, b} + 64);
  endfunction

  task automatic model_store(input logic [31:0] b, input logic [31:0] a);
    int h = find(b);
    logic [63:0] aa = {32'h0, a};
    logic [63:0] bb = {32'h0, b};
    if (aa < bb || aa >= bb + 64) return;
    if (h >= 0) begin
      if (aa + 1 > me[h]) me[h] = aa + 1;
    end else begin
      mv[mptr] = 1; mb[mptr] = b; me[mptr] = aa + 1;
      mptr = (mptr + 1) % N;
      if (mcnt < N) mcnt++;
    end
  endtask

  // One clock: drive the inputs, advance the model, check the registered outputs.
  task automatic cycle(input bit sv, input logic [31:0] sb, input logic [31:0] sa,
                       input bit lv, input logic [31:0] lb, input logic [31:0] la,
                       input bit clr);
    bit exp_ovf;
    st_valid_i = sv; st_base_i = sb; st_addr_i = sa;
    ld_valid_i = lv; ld_base_i = lb; ld_addr_i = la;
    clear_i = clr;
    exp_ovf = !clr && lv && model_load(lb, la);
    if (clr) model_reset(0);
    else if (sv) model_store(sb, sa);
    @(posedge clk_i); #1;
    st_valid_i = 0; ld_valid_i = 0; clear_i = 0;
    chk("overflow", overflow_o, exp_ovf);
    chk("count", count_o, mcnt);
    chk("full", full_o, mcnt == N);
  endtask

  task automatic check_dbg();
    for (int i = 0; i < N; i++) begin
      dbg_idx_i = i[2:0]; #1;
      if (mv[i]) begin
        chk("dbg_base", dbg_base_o, mb[i]);
        chk("dbg_end", dbg_end_o, me[i][31:0]);
      end
    end
  endtask

  initial begin
    logic [31:0] b, a, lb2, la2;
    model_reset(1);
    #15; // reset asserted away from edges
    for (int i = 0; i < N; i++) begin
      dbg_idx_i = i[2:0]; #1;
      chk("rst_dbg_base", dbg_base_o, 0);
      chk("rst_dbg_end", dbg_end_o, 0);
    end
    chk("rst_ovf", overflow_o, 0);
    chk("rst_count", count_o, 0);
    chk("rst_full", full_o, 0);
    @(negedge clk_i); rst_ni = 1;
    @(posedge clk_i); #1;

    // Fill run, in-bounds load, overread, limit
    for (int k = 0; k < 8; k++) cycle(1, 32'h1000, 32'h1000 + k, 0, 0, 0, 0);
    dbg_idx_i = 0; #1;
    chk("fill_end", dbg_end_o, 32'h1008);
    cycle(0, 0, 0, 1, 32'h1000, 32'h1004, 0);
    cycle(0, 0, 0, 1, 32'h1000, 32'h1008, 0);
    chk("overread", overflow_o, 1);
    cycle(0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 32'h1000, 32'h1040, 0);
    chk("at_lim", overflow_o, 0);

    // Same-cycle store and load sees pre-store end
    cycle(1, 32'h1000, 32'h1008, 1, 32'h1000, 32'h1008, 0);
    chk("same_cycle", overflow_o, 1);
    cycle(0, 0, 0, 1, 32'h1000, 32'h1008, 0);
    chk("after_store", overflow_o, 0);

    // Clear dominates a store
    cycle(1, 32'h1000, 32'h1009, 1, 32'h1000, 32'h1020, 1);
    chk("clear_count", count_o, 0);
    cycle(0, 0, 0, 1, 32'h1000, 32'h1020, 0);
    chk("clear_nomatch", overflow_o, 0);

    // Replacement of oldest entry
    for (int k = 0; k < 9; k++) cycle(1, 32'h2000 + 32'h100 * k, 32'h2000 + 32'h100 * k, 0, 0, 0, 0);
    chk("repl_count", count_o, 8);
    chk("repl_full", full_o, 1);
    dbg_idx_i = 0; #1;
    chk("repl_base0", dbg_base_o, 32'h2800);
    check_dbg();
    cycle(0, 0, 0, 1, 32'h2000, 32'h2001, 0);
    chk("repl_evicted", overflow_o, 0);

    // Top-of-space arithmetic and window rejection
    cycle(0, 0, 0, 0, 0, 0, 1);
    cycle(1, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 0, 0, 0, 0);
    chk("top_count", count_o, 1);
    dbg_idx_i = 0; #1;
    chk("top_end", dbg_end_o, 0);
    cycle(1, 32'h3000, 32'h3040, 0, 0, 0, 0);
    chk("win_reject", count_o, 1);
    cycle(1, 32'hFFFF_FFF0, 32'hFFFF_FFF0 + 32'd64, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 0);
    chk("top_below_end", overflow_o, 0);

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      b = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFE0 : 32'h4000 + 32'h100 * $urandom_range(0, 11);
      a = b + $urandom_range(0, 80);
      lb2 = ($urandom_range(0, 1) != 0) ? b : 32'h4000 + 32'h100 * $urandom_range(0, 11);
      la2 = lb2 + $urandom_range(0, 80) - 4;
      cycle($urandom_range(0, 3) != 0, b, a, $urandom_range(0, 2) != 0, lb2, la2,
            $urandom_range(0, 99) == 0);
      if (n % 100 == 99) check_dbg();
    end

    // Async reset drops an in-flight overflow
    cycle(0, 0, 0, 0, 0, 0, 1);
    cycle(1, 32'h5000, 32'h5000, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 32'h5000, 32'h5001, 0);
    chk("pre_rst_ovf", overflow_o, 1);
    #2 rst_ni = 0;
    #1;
    chk("async_ovf", overflow_o, 0);
    chk("async_count", count_o, 0);
    dbg_idx_i = 0; #1;
    chk("async_dbg_end", dbg_end_o, 0);
    model_reset(1);
    @(negedge clk_i); rst_ni = 1;
    cycle(0, 0, 0, 1, 32'h5000, 32'h5001, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end
endmodule
